// File: rtl/runway_traffic_ctrl.sv
// Runway arbiter: two ID FIFOs (landing, takeoff) and a one-runway grant FSM.
// One edge from a queued request to a grant, one edge from runway_done back to IDLE. Requests to a full or blocked queue are dropped and flagged the next cycle.
module runway_traffic_ctrl #(
  parameter int QDEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       landing_request,
  input  logic [3:0] landing_id,
  input  logic       takeoff_request,
  input  logic [3:0] takeoff_id,
  input  logic       runway_done,
  input  logic [1:0] ECSU_state,
  input  logic       emergency_landing_alert,
  output logic       grant_valid,
  output logic [3:0] grant_id,
  output logic       grant_is_landing,
  output logic       runway_busy,
  output logic [2:0] landing_count,
  output logic [2:0] takeoff_count,
  output logic       request_rejected,
  output logic [1:0] RTC_state
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_LANDING = 2'b01,
    S_TAKEOFF = 2'b10
  } state_t;

  state_t          r_state;
  logic [3:0]      r_lq [QDEPTH];
  logic [3:0]      r_tq [QDEPTH];
  logic [AW-1:0]   r_lwr, r_lrd, r_twr, r_trd;
  logic [2:0]      r_lcnt, r_tcnt;
  logic            r_gv, r_gil, r_busy, r_rej;
  logic [3:0]      r_gid;

  logic w_l_full, w_t_full, w_t_block, w_t_ok;
  logic w_l_push, w_t_push, w_l_pop, w_t_pop, w_rej;

  assign w_l_full  = (r_lcnt == 3'(QDEPTH));
  assign w_t_full  = (r_tcnt == 3'(QDEPTH));
  assign w_t_block = emergency_landing_alert || (ECSU_state == 2'b11);
  assign w_t_ok    = !ECSU_state[1] && !emergency_landing_alert;

  // Fullness is judged before any same-edge pop, so a full queue always drops.
  assign w_l_push  = landing_request && !w_l_full;
  assign w_t_push  = takeoff_request && !w_t_full && !w_t_block;
  assign w_rej     = (landing_request && w_l_full) ||
                     (takeoff_request && (w_t_full || w_t_block));

  assign w_l_pop   = (r_state == S_IDLE) && (r_lcnt != 3'd0);
  assign w_t_pop   = (r_state == S_IDLE) && (r_lcnt == 3'd0) &&
                     (r_tcnt != 3'd0) && w_t_ok;

  always_ff @(posedge CLK) begin
    if (!RST && w_l_push) r_lq[r_lwr] <= landing_id;
    if (!RST && w_t_push) r_tq[r_twr] <= takeoff_id;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_lwr  <= '0;
      r_lrd  <= '0;
      r_twr  <= '0;
      r_trd  <= '0;
      r_lcnt <= 3'd0;
      r_tcnt <= 3'd0;
      r_rej  <= 1'b0;
    end else begin
      if (w_l_push) r_lwr <= r_lwr + AW'(1);
      if (w_l_pop)  r_lrd <= r_lrd + AW'(1);
      if (w_t_push) r_twr <= r_twr + AW'(1);
      if (w_t_pop)  r_trd <= r_trd + AW'(1);
      r_lcnt <= r_lcnt + 3'(w_l_push) - 3'(w_l_pop);
      r_tcnt <= r_tcnt + 3'(w_t_push) - 3'(w_t_pop);
      r_rej  <= w_rej;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_gv    <= 1'b0;
      r_gid   <= 4'd0;
      r_gil   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_gv <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_l_pop) begin
            r_state <= S_LANDING;
            r_gv    <= 1'b1;
            r_gid   <= r_lq[r_lrd];
            r_gil   <= 1'b1;
            r_busy  <= 1'b1;
          end else if (w_t_pop) begin
            r_state <= S_TAKEOFF;
            r_gv    <= 1'b1;
            r_gid   <= r_tq[r_trd];
            r_gil   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_LANDING, S_TAKEOFF: begin
          // An operation in progress only ends on runway_done, whatever the weather.
          if (runway_done) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant_valid      = r_gv;
  assign grant_id         = r_gid;
  assign grant_is_landing = r_gil;
  assign runway_busy      = r_busy;
  assign landing_count    = r_lcnt;
  assign takeoff_count    = r_tcnt;
  assign request_rejected = r_rej;
  assign RTC_state        = r_state;

endmodule

// File: tb/tb_runway_traffic_ctrl.sv
// Bench for runway_traffic_ctrl: directed scenarios with literal expectations,
// then random traffic compared cycle by cycle against a queue-based model.
module tb_runway_traffic_ctrl;

  localparam int QD = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       landing_request = 1'b0;
  logic [3:0] landing_id = 4'd0;
  logic       takeoff_request = 1'b0;
  logic [3:0] takeoff_id = 4'd0;
  logic       runway_done = 1'b0;
  logic [1:0] ECSU_state = 2'b00;
  logic       emergency_landing_alert = 1'b0;
  logic       grant_valid;
  logic [3:0] grant_id;
  logic       grant_is_landing;
  logic       runway_busy;
  logic [2:0] landing_count;
  logic [2:0] takeoff_count;
  logic       request_rejected;
  logic [1:0] RTC_state;

  int errors = 0;
  int checks = 0;

  // Reference model: plain queues plus the runway occupant.
  int         lq[$];
  int         tq[$];
  int         m_mode = 0;   // 0 idle, 1 landing, 2 takeoff
  logic       m_gv = 1'b0;
  logic [3:0] m_gid = 4'd0;
  logic       m_gil = 1'b0;
  logic       m_rej = 1'b0;

  runway_traffic_ctrl #(.QDEPTH(QD)) dut (
    .CLK(CLK), .RST(RST),
    .landing_request(landing_request), .landing_id(landing_id),
    .takeoff_request(takeoff_request), .takeoff_id(takeoff_id),
    .runway_done(runway_done), .ECSU_state(ECSU_state),
    .emergency_landing_alert(emergency_landing_alert),
    .grant_valid(grant_valid), .grant_id(grant_id),
    .grant_is_landing(grant_is_landing), .runway_busy(runway_busy),
    .landing_count(landing_count), .takeoff_count(takeoff_count),
    .request_rejected(request_rejected), .RTC_state(RTC_state)
  );

  always #5 CLK = ~CLK;

  task automatic cycle(input logic rst, input logic lr, input logic [3:0] lid,
                       input logic tr, input logic [3:0] tid, input logic done,
                       input logic [1:0] ecsu, input logic alert);
    bit l_full, t_full, t_ok;
    RST = rst; landing_request = lr; landing_id = lid;
    takeoff_request = tr; takeoff_id = tid; runway_done = done;
    ECSU_state = ecsu; emergency_landing_alert = alert;
    @(posedge CLK);
    if (rst) begin
      lq.delete(); tq.delete();
      m_mode = 0; m_gv = 0; m_gid = 0; m_gil = 0; m_rej = 0;
    end else begin
      l_full = (lq.size() == QD);
      t_full = (tq.size() == QD);
      t_ok   = (ecsu < 2) && !alert;
      m_rej  = (lr && l_full) || (tr && (t_full || alert || ecsu == 2'b11));
      m_gv   = 0;
      if (m_mode != 0) begin
        if (done) m_mode = 0;
      end else if (lq.size() > 0) begin
        m_gid = 4'(lq.pop_front()); m_gil = 1; m_gv = 1; m_mode = 1;
      end else if (tq.size() > 0 && t_ok) begin
        m_gid = 4'(tq.pop_front()); m_gil = 0; m_gv = 1; m_mode = 2;
      end
      if (lr && !l_full) lq.push_back(int'(lid));
      if (tr && !t_full && !(alert || ecsu == 2'b11)) tq.push_back(int'(tid));
    end
    #1;
  endtask

  task automatic idle(input logic [1:0] ecsu = 2'b00);
    cycle(0, 0, 0, 0, 0, 0, ecsu, 0);
  endtask

  task automatic test_reset;
    cycle(1, 0, 0, 0, 0, 0, 2'b00, 0);
    cycle(1, 1, 4'd3, 1, 4'd4, 1, 2'b00, 0);
    checks++;
    if ({grant_valid, grant_id, grant_is_landing, runway_busy, landing_count,
         takeoff_count, request_rejected, RTC_state} !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: got gv=%b id=%0d il=%b busy=%b lc=%0d tc=%0d rej=%b st=%0d required all zero",
               grant_valid, grant_id, grant_is_landing, runway_busy, landing_count,
               takeoff_count, request_rejected, RTC_state);
    end
  endtask

  task automatic test_landing_basic;
    cycle(1, 0, 0, 0, 0, 0, 2'b00, 0);
    cycle(0, 1, 4'd5, 0, 0, 0, 2'b00, 0);
    checks++;
    if (grant_valid !== 1'b0 || landing_count !== 3'd1) begin
      errors++;
      $display("FAIL land_early: got gv=%b lc=%0d required gv=0 lc=1", grant_valid, landing_count);
    end
    idle();
    checks++;
    if (grant_valid !== 1'b1 || grant_id !== 4'd5 || grant_is_landing !== 1'b1 ||
        runway_busy !== 1'b1 || RTC_state !== 2'b01 || landing_count !== 3'd0) begin
      errors++;
      $display("FAIL land_grant: got gv=%b id=%0d il=%b busy=%b st=%0d lc=%0d required 1 5 1 1 1 0",
               grant_valid, grant_id, grant_is_landing, runway_busy, RTC_state, landing_count);
    end
    idle();
    checks++;
    if (grant_valid !== 1'b0 || runway_busy !== 1'b1) begin
      errors++;
      $display("FAIL land_hold: got gv=%b busy=%b required gv=0 busy=1", grant_valid, runway_busy);
    end
    cycle(0, 0, 0, 0, 0, 1, 2'b00, 0);
    checks++;
    if (runway_busy !== 1'b0 || RTC_state !== 2'b00 || grant_id !== 4'd5) begin
      errors++;
      $display("FAIL land_done: got busy=%b st=%0d id=%0d required busy=0 st=0 id=5",
               runway_busy, RTC_state, grant_id);
    end
  endtask

  task automatic test_priority;
    logic [3:0] exp_id [3];
    logic       exp_il [3];
    exp_id[0] = 4'd9; exp_id[1] = 4'd1; exp_id[2] = 4'd2;
    exp_il[0] = 1'b1; exp_il[1] = 1'b0; exp_il[2] = 1'b0;
    cycle(1, 0, 0, 0, 0, 0, 2'b00, 0);
    cycle(0, 1, 4'd4, 0, 0, 0, 2'b00, 0);
    idle();
    cycle(0, 0, 0, 1, 4'd1, 0, 2'b00, 0);
    cycle(0, 0, 0, 1, 4'd2, 0, 2'b00, 0);
    cycle(0, 1, 4'd9, 0, 0, 0, 2'b00, 0);
    checks++;
    if (takeoff_count !== 3'd2 || landing_count !== 3'd1 || RTC_state !== 2'b01) begin
      errors++;
      $display("FAIL prio_queued: got tc=%0d lc=%0d st=%0d required 2 1 1",
               takeoff_count, landing_count, RTC_state);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0, 1, 2'b00, 0);
      checks++;
      if (grant_valid !== 1'b0 || RTC_state !== 2'b00) begin
        errors++;
        $display("FAIL prio_gap%0d: got gv=%b st=%0d required gv=0 st=0", i, grant_valid, RTC_state);
      end
      idle();
      checks++;
      if (grant_valid !== 1'b1 || grant_id !== exp_id[i] || grant_is_landing !== exp_il[i]) begin
        errors++;
        $display("FAIL prio_grant%0d: got gv=%b id=%0d il=%b required gv=1 id=%0d il=%b",
                 i, grant_valid, grant_id, grant_is_landing, exp_id[i], exp_il[i]);
      end
    end
    cycle(0, 0, 0, 0, 0, 1, 2'b00, 0);
  endtask

  task automatic test_weather_hold;
    cycle(1, 0, 0, 0, 0, 0, 2'b10, 0);
    cycle(0, 0, 0, 1, 4'd3, 0, 2'b10, 0);
    for (int i = 0; i < 3; i++) begin
      idle(2'b10);
      checks++;
      if (grant_valid !== 1'b0 || takeoff_count !== 3'd1 || RTC_state !== 2'b00) begin
        errors++;
        $display("FAIL wx_hold%0d: got gv=%b tc=%0d st=%0d required 0 1 0",
                 i, grant_valid, takeoff_count, RTC_state);
      end
    end
    idle(2'b00);
    checks++;
    if (grant_valid !== 1'b1 || grant_id !== 4'd3 || grant_is_landing !== 1'b0 ||
        RTC_state !== 2'b10 || takeoff_count !== 3'd0) begin
      errors++;
      $display("FAIL wx_release: got gv=%b id=%0d il=%b st=%0d tc=%0d required 1 3 0 2 0",
               grant_valid, grant_id, grant_is_landing, RTC_state, takeoff_count);
    end
    // Worsening weather must not abort a takeoff already granted.
    idle(2'b11);
    checks++;
    if (RTC_state !== 2'b10 || runway_busy !== 1'b1) begin
      errors++;
      $display("FAIL wx_no_abort: got st=%0d busy=%b required st=2 busy=1", RTC_state, runway_busy);
    end
    cycle(0, 0, 0, 0, 0, 1, 2'b00, 0);
  endtask

  task automatic test_overflow;
    int rej_pulses = 0;
    cycle(1, 0, 0, 0, 0, 0, 2'b00, 0);
    cycle(0, 1, 4'd1, 0, 0, 0, 2'b00, 0);
    idle();
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 4'(10 + i), 0, 0, 0, 2'b00, 0);
      if (request_rejected === 1'b1) rej_pulses++;
    end
    checks++;
    if (landing_count !== 3'd4) begin
      errors++;
      $display("FAIL ovf_count: got lc=%0d required 4", landing_count);
    end
    idle();
    if (request_rejected === 1'b1) rej_pulses++;
    checks++;
    if (rej_pulses !== 1) begin
      errors++;
      $display("FAIL ovf_reject_pulses: got %0d required 1", rej_pulses);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0, 0, 1, 2'b00, 0);
      idle();
      checks++;
      if (grant_valid !== 1'b1 || grant_id !== 4'(10 + i) || grant_is_landing !== 1'b1) begin
        errors++;
        $display("FAIL ovf_order%0d: got gv=%b id=%0d il=%b required gv=1 id=%0d il=1",
                 i, grant_valid, grant_id, grant_is_landing, 10 + i);
      end
    end
    cycle(0, 0, 0, 0, 0, 1, 2'b00, 0);
  endtask

  task automatic test_emergency_reject;
    cycle(1, 0, 0, 0, 0, 0, 2'b00, 0);
    cycle(0, 1, 4'd2, 0, 0, 0, 2'b00, 0);
    idle();
    cycle(0, 0, 0, 1, 4'd6, 0, 2'b00, 0);
    cycle(0, 0, 0, 1, 4'd7, 0, 2'b00, 1);
    checks++;
    if (request_rejected !== 1'b1 || takeoff_count !== 3'd1) begin
      errors++;
      $display("FAIL emerg_reject: got rej=%b tc=%0d required rej=1 tc=1", request_rejected, takeoff_count);
    end
    cycle(0, 0, 0, 0, 0, 1, 2'b00, 1);
    cycle(0, 0, 0, 0, 0, 0, 2'b00, 1);
    checks++;
    if (grant_valid !== 1'b0 || takeoff_count !== 3'd1 || request_rejected !== 1'b0) begin
      errors++;
      $display("FAIL emerg_hold: got gv=%b tc=%0d rej=%b required 0 1 0",
               grant_valid, takeoff_count, request_rejected);
    end
    idle();
    checks++;
    if (grant_valid !== 1'b1 || grant_id !== 4'd6 || grant_is_landing !== 1'b0) begin
      errors++;
      $display("FAIL emerg_release: got gv=%b id=%0d il=%b required 1 6 0",
               grant_valid, grant_id, grant_is_landing);
    end
    cycle(0, 0, 0, 0, 0, 1, 2'b00, 0);
  endtask

  task automatic test_reset_mid_op;
    cycle(1, 0, 0, 0, 0, 0, 2'b00, 0);
    cycle(0, 1, 4'd1, 0, 0, 0, 2'b00, 0);
    idle();
    cycle(0, 0, 0, 1, 4'd3, 0, 2'b00, 0);
    cycle(0, 0, 0, 0, 0, 1, 2'b00, 0);
    idle();
    cycle(0, 1, 4'd8, 0, 0, 0, 2'b00, 0);
    cycle(0, 0, 0, 1, 4'd9, 0, 2'b00, 0);
    checks++;
    if (RTC_state !== 2'b10 || landing_count !== 3'd1 || takeoff_count !== 3'd1) begin
      errors++;
      $display("FAIL rstop_setup: got st=%0d lc=%0d tc=%0d required 2 1 1",
               RTC_state, landing_count, takeoff_count);
    end
    cycle(1, 1, 4'd4, 1, 4'd5, 1, 2'b00, 0);
    checks++;
    if (RTC_state !== 2'b00 || landing_count !== 3'd0 || takeoff_count !== 3'd0 ||
        runway_busy !== 1'b0 || grant_valid !== 1'b0 || grant_id !== 4'd0) begin
      errors++;
      $display("FAIL rstop_cleared: got st=%0d lc=%0d tc=%0d busy=%b gv=%b id=%0d required all zero",
               RTC_state, landing_count, takeoff_count, runway_busy, grant_valid, grant_id);
    end
    idle();
    checks++;
    if (grant_valid !== 1'b0 || RTC_state !== 2'b00) begin
      errors++;
      $display("FAIL rstop_no_grant: got gv=%b st=%0d required 0 0", grant_valid, RTC_state);
    end
  endtask

  task automatic test_random;
    cycle(1, 0, 0, 0, 0, 0, 2'b00, 0);
    for (int n = 0; n < 1500; n++) begin
      cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 35), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 99) < 35), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 99) < 25), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 99) < 10));
      checks++;
      if (grant_valid !== m_gv || grant_id !== m_gid || grant_is_landing !== m_gil ||
          runway_busy !== (m_mode != 0) || RTC_state !== 2'(m_mode) ||
          landing_count !== 3'(lq.size()) || takeoff_count !== 3'(tq.size()) ||
          request_rejected !== m_rej) begin
        errors++;
        $display("FAIL rand_cycle%0d: got gv=%b id=%0d il=%b busy=%b st=%0d lc=%0d tc=%0d rej=%b required gv=%b id=%0d il=%b busy=%b st=%0d lc=%0d tc=%0d rej=%b",
                 n, grant_valid, grant_id, grant_is_landing, runway_busy, RTC_state,
                 landing_count, takeoff_count, request_rejected,
                 m_gv, m_gid, m_gil, (m_mode != 0), m_mode, lq.size(), tq.size(), m_rej);
      end
    end
  endtask

  initial begin
    test_reset();
    test_landing_basic();
    test_priority();
    test_weather_hold();
    test_overflow();
    test_emergency_reject();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/runway_traffic_ctrl.md
RUNWAY_TRAFFIC_CTRL -- requirements
Module: runway_traffic_ctrl

Interface
REQ-001 SHALL have parameter QDEPTH, default 4, entries per request queue; only power-of-two values are supported.
REQ-002 SHALL have port CLK  input  1  single clock; all logic updates on the rising edge.
REQ-003 SHALL have port RST  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port landing_request  input  1  one-cycle pulse; a plane asks to land.
REQ-005 SHALL have port landing_id  input  4  plane identifier, sampled with landing_request.
REQ-006 SHALL have port takeoff_request  input  1  one-cycle pulse; a plane asks to take off.
REQ-007 SHALL have port takeoff_id  input  4  plane identifier, sampled with takeoff_request.
REQ-008 SHALL have port runway_done  input  1  one-cycle pulse; the current runway operation has finished.
REQ-009 SHALL have port ECSU_state  input  2  weather state from the environmental unit: 00 clear, 01 caution, 10 severe, 11 emergency.
REQ-010 SHALL have port emergency_landing_alert  input  1  emergency flag from the environmental unit.
REQ-011 SHALL have port grant_valid  output  1  one-cycle pulse; runway granted.
REQ-012 SHALL have port grant_id  output  4  plane granted; held until the next grant.
REQ-013 SHALL have port grant_is_landing  output  1  1 = landing grant, 0 = takeoff grant; held with grant_id.
REQ-014 SHALL have port runway_busy  output  1  high while an operation is in progress.
REQ-015 SHALL have port landing_count  output  3  landing queue occupancy.
REQ-016 SHALL have port takeoff_count  output  3  takeoff queue occupancy.
REQ-017 SHALL have port request_rejected  output  1  one-cycle pulse; a request was dropped.
REQ-018 SHALL have port RTC_state  output  2  controller state: 00 IDLE, 01 LANDING, 10 TAKEOFF.

Function
REQ-019 SHALL hold two independent FIFOs (landing, takeoff) of QDEPTH 4-bit IDs; each SHALL pop oldest-first.
REQ-020 SHALL push a sampled request at the same rising edge; landing and takeoff requests in the same cycle SHALL both be accepted.
REQ-021 SHALL drop a request to a full queue, leaving contents and count unchanged, and pulse request_rejected the next cycle.
REQ-022 SHALL drop takeoff requests while emergency_landing_alert=1 or ECSU_state=11, and pulse request_rejected.
REQ-023 SHALL, on a push and a pop of the same queue in the same edge, perform both; the count stays unchanged.
REQ-024 SHALL define takeoff as permitted only when ECSU_state is 00 or 01 and emergency_landing_alert=0.
REQ-025 SHALL, in IDLE with the landing queue non-empty, pop the landing head, load grant_id/grant_is_landing=1, pulse grant_valid, and move to LANDING at one edge.
REQ-026 SHALL, in IDLE with the landing queue empty, the takeoff queue non-empty and takeoff permitted, do the same with grant_is_landing=0 and move to TAKEOFF.
REQ-027 SHALL give landing strict priority over takeoff.
REQ-028 SHALL retain takeoff queue contents, without popping, while takeoff is not permitted.
REQ-029 SHALL, in LANDING or TAKEOFF, return to IDLE at the edge sampling runway_done=1; the next grant is no earlier than the following edge.
REQ-030 SHALL ignore runway_done while in IDLE.
REQ-031 SHALL let an in-progress TAKEOFF run to runway_done when weather worsens; it is never aborted.
REQ-032 SHALL drive runway_busy high exactly when RTC_state is LANDING or TAKEOFF.
REQ-033 SHALL, for a request to an empty queue in IDLE sampled at edge k, assert grant_valid for the cycle after edge k+1.
REQ-034 SHALL register all outputs; no combinational input-to-output path.

Reset
REQ-035 SHALL, on RST=1 at a rising edge, empty both queues and set RTC_state=00, grant_valid=0, grant_id=0, grant_is_landing=0, runway_busy=0, both counts=0, request_rejected=0.
REQ-036 SHALL give RST priority over all requests, runway_done and the state machine in that cycle; an in-progress operation mid-reset is discarded without a grant.

Verification
REQ-037 SHALL cover: landing_request id=5 in IDLE, ECSU=00 -> grant_valid one cycle after next edge, grant_id=5, grant_is_landing=1, runway_busy=1 until runway_done.
REQ-038 SHALL cover: takeoff ids 1,2 queued, then landing id=9, runway busy -> after runway_done grants 9, then 1, then 2.
REQ-039 SHALL cover: takeoff id=3 queued, ECSU=10 -> no grant, takeoff_count=1; ECSU->00 -> grant id=3, grant_is_landing=0.
REQ-040 SHALL cover: 5 landing requests with runway busy -> landing_count=4, one request_rejected pulse, later grants in order.
REQ-041 SHALL cover: emergency_landing_alert=1 with takeoff_request id=7 -> request_rejected=1, takeoff_count unchanged.
REQ-042 SHALL cover: RST during TAKEOFF with both queues non-empty -> next cycle RTC_state=00, counts=0, runway_busy=0.
